instr_mem_pipe: RTL

INSTR_MEM_PIPE -- requirements
Module: instr_mem_pipe

---
 rtl/instr_mem_pipe_if.sv | 20 ++
 rtl/instr_mem_pipe.sv | 43 ++++
 2 files changed

// File: rtl/instr_mem_pipe_if.sv
// instr_mem_pipe_if: fetch request/response and program-load signals for instr_mem_pipe
interface instr_mem_pipe_if #(parameter int AW = 6);
  logic          ReqValid;
  logic          ReqReady;
  logic [63:0]   Address;
  logic          RspValid;
  logic [31:0]   Data;
  logic          Fault;
  logic          LoadEn;
  logic [AW-1:0] LoadAddr;
  logic [31:0]   LoadData;
  modport master (
    output ReqValid, Address, LoadEn, LoadAddr, LoadData,
    input  ReqReady, RspValid, Data, Fault
  );
  modport slave (
    input  ReqValid, Address, LoadEn, LoadAddr, LoadData,
    output ReqReady, RspValid, Data, Fault
  );
endinterface

// File: rtl/instr_mem_pipe.sv
// instr_mem_pipe: loadable instruction memory with a fixed-latency, fully pipelined fetch port
module instr_mem_pipe #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2,
  parameter int AW      = $clog2(DEPTH)
) (
  input logic CLK,
  input logic Reset,
  instr_mem_pipe_if.slave bus
);
  logic [31:0] mem [DEPTH] = '{default: '0};
  logic acc;
  logic bad;
  logic [AW-1:0] idx;
  logic [LATENCY-1:0] v;
  logic [LATENCY-1:0] f;
  logic [31:0] d [LATENCY];
  assign bus.ReqReady = !Reset && !bus.LoadEn;
  assign acc = bus.ReqValid && bus.ReqReady;
  assign bad = (|bus.Address[1:0]) || (bus.Address >= 64'(4 * DEPTH));
  assign idx = bus.Address[AW+1:2];
  always_ff @(posedge CLK)
    if (!Reset && bus.LoadEn) mem[bus.LoadAddr] <= bus.LoadData;
  // only valid bits are reset; payload is gated by valid at the output
  always_ff @(posedge CLK) begin
    if (Reset) v <= '0;
    else begin
      v[0] <= acc;
      for (int i = 1; i < LATENCY; i++) v[i] <= v[i-1];
    end
  end
  always_ff @(posedge CLK) begin
    d[0] <= bad ? 32'h0 : mem[idx];
    f[0] <= bad;
    for (int i = 1; i < LATENCY; i++) begin
      d[i] <= d[i-1];
      f[i] <= f[i-1];
    end
  end
  assign bus.RspValid = v[LATENCY-1];
  assign bus.Data     = v[LATENCY-1] ? d[LATENCY-1] : 32'h0;
  assign bus.Fault    = v[LATENCY-1] && f[LATENCY-1];
endmodule
